// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types and instruction field positions for the bitty core.
//   op_e    : ALU operation encoding (instruction bits [4:2])
//   state_e : instruction sequencing states
//   *_LO    : low bit position of each instruction field
package bitty_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned REG_SEL_W = 3;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned OP_W      = 3;

  localparam int unsigned RX_LO   = 13;
  localparam int unsigned RY_LO   = 10;
  localparam int unsigned IMM_LO  = 5;
  localparam int unsigned OP_LO   = 2;
  localparam int unsigned NOP_BIT = 1;
  localparam int unsigned IMM_BIT = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    EXEC   = 2'd2,
    WRITE  = 2'd3
  } state_e;

endpackage

// File: rtl/bitty_alu_p.sv
// bitty_alu_p: combinational ALU for the bitty core.
//   a_i      : first operand (S register)
//   b_i      : second operand (register or zero-extended immediate)
//   op_i     : operation select
//   result_o : WIDTH-bit result, modulo 2^WIDTH
//   carry_o  : carry-out (add), borrow (sub), last bit shifted out (shl/shr), else 0
module bitty_alu_p
  import bitty_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] amt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_w;
  logic [WIDTH:0] shr_w;

  // Shifts run on a one-bit-extended copy so the last bit shifted out lands
  // in the extra bit; a zero shift leaves that bit clear.
  always_comb begin
    amt   = b_i[SHW-1:0];
    sum   = {1'b0, a_i} + {1'b0, b_i};
    diff  = {1'b0, a_i} - {1'b0, b_i};
    shl_w = {1'b0, a_i} << amt;
    shr_w = {a_i, 1'b0} >> amt;

    result_o = '0;
    carry_o  = 1'b0;
    unique case (op_i)
      OP_ADD: begin result_o = sum[WIDTH-1:0];  carry_o = sum[WIDTH];  end
      OP_SUB: begin result_o = diff[WIDTH-1:0]; carry_o = diff[WIDTH]; end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SHL: begin result_o = shl_w[WIDTH-1:0]; carry_o = shl_w[WIDTH]; end
      OP_SHR: begin result_o = shr_w[WIDTH:1];   carry_o = shr_w[0];     end
      OP_CMP: begin
        if (a_i == b_i)     result_o = '0;
        else if (a_i < b_i) result_o = WIDTH'(1);
        else                result_o = WIDTH'(2);
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/bitty_param.sv
// bitty_param: four-state (IDLE/LOAD_S/EXEC/WRITE) accumulator-style core.
//   clk, reset  : clock, synchronous active-high reset
//   d_instr     : 16-bit instruction, captured on instr_valid && instr_ready
//   instr_ready : high in IDLE (and not in reset)
//   d_out       : C register (last ALU result)
//   done        : one-cycle pulse during WRITE
//   flags       : {neg, carry, zero}; generated only when BITTY_FLAGS_EN is
//                 defined, otherwise tied to 3'b000
module bitty_param
  import bitty_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [WIDTH-1:0]   d_out,
  output logic               done,
  output logic [2:0]         flags
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e             state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   c_q;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic               done_q;

  // Instruction field decode from the captured word
  logic [REG_SEL_W-1:0] rx, ry;
  logic [IMM_W-1:0]     imm8;
  op_e                  op;
  logic                 nop, imm_mode;

  assign rx       = instr_q[RX_LO +: REG_SEL_W];
  assign ry       = instr_q[RY_LO +: REG_SEL_W];
  assign imm8     = instr_q[IMM_LO +: IMM_W];
  assign op       = op_e'(instr_q[OP_LO +: OP_W]);
  assign nop      = instr_q[NOP_BIT];
  assign imm_mode = instr_q[IMM_BIT];

  // Two read ports; selectors past the register file read as zero
  logic             rx_ok, ry_ok;
  logic [IDX_W-1:0] rx_idx, ry_idx;
  logic [WIDTH-1:0] rd_x, rd_y, operand;

  assign rx_ok   = 32'(rx) < NREGS;
  assign ry_ok   = 32'(ry) < NREGS;
  assign rx_idx  = IDX_W'(rx);
  assign ry_idx  = IDX_W'(ry);
  assign rd_x    = rx_ok ? regs_q[rx_idx] : '0;
  assign rd_y    = ry_ok ? regs_q[ry_idx] : '0;
  assign operand = imm_mode ? WIDTH'(imm8) : rd_y;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  bitty_alu_p #(.WIDTH(WIDTH)) u_alu (
    .a_i      (s_q),
    .b_i      (operand),
    .op_i     (op),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  // Sequencer and datapath; reset wins over a same-cycle handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      s_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= d_instr;
            state_q <= LOAD_S;
          end
        end
        LOAD_S: begin
          s_q     <= rd_x;
          state_q <= EXEC;
        end
        EXEC: begin
          if (!nop) c_q <= alu_res;
          done_q  <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          if (!nop && rx_ok) regs_q[rx_idx] <= c_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE) && !reset;
  assign d_out       = c_q;
  assign done        = done_q;

`ifdef BITTY_FLAGS_EN
  logic [2:0] flags_q;

  // Flags follow the ALU result as it is latched into C
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (state_q == EXEC && !nop) begin
      flags_q <= {alu_res[WIDTH-1], alu_carry, (alu_res == '0)};
    end
  end

  assign flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign flags        = 3'b000;
`endif

endmodule

// File: tb/tb_bitty_param.sv
// tb_bitty_param: directed bench for bitty_param (16-bit/8-reg and 8-bit/4-reg builds).
module tb_bitty_param;
  import bitty_pkg::*;

`ifdef BITTY_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ins16, ins8;
  logic        v16, v8;
  logic        rdy16, rdy8;
  logic [15:0] out16;
  logic [7:0]  out8;
  logic        done16, done8;
  logic [2:0]  fl16, fl8;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bitty_param #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .reset(reset), .d_instr(ins16), .instr_valid(v16),
    .instr_ready(rdy16), .d_out(out16), .done(done16), .flags(fl16)
  );

  bitty_param #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk(clk), .reset(reset), .d_instr(ins8), .instr_valid(v8),
    .instr_ready(rdy8), .d_out(out8), .done(done8), .flags(fl8)
  );

  function automatic logic [15:0] enc_i(logic [2:0] op, logic [2:0] rx, logic [7:0] imm);
    return {rx, imm, op, 1'b0, 1'b1};
  endfunction

  function automatic logic [15:0] enc_r(logic [2:0] op, logic [2:0] rx, logic [2:0] ry);
    return {rx, ry, 5'b00000, op, 1'b0, 1'b0};
  endfunction

  function automatic logic [31:0] fx(logic [2:0] f);
    return FLAGS_ON ? 32'(f) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake one instruction, verify ready and done timing, return d_out
  // sampled in the done cycle. keep=1 leaves instr_valid high with a junk
  // word while busy. Called just after a rising edge with the DUT idle.
  task automatic issue(input bit sel, input bit keep, input logic [15:0] ins,
                       input string tag, output logic [31:0] res);
    logic [2:0] dv;
    if (sel) begin ins8 = ins; v8 = 1'b1; end
    else     begin ins16 = ins; v16 = 1'b1; end
    @(negedge clk);
    if (sel) check({tag, "_ready"}, 32'(rdy8), 32'd1);
    else     check({tag, "_ready"}, 32'(rdy16), 32'd1);
    @(posedge clk); #1;
    if (keep) begin
      ins16 = enc_i(OP_ADD, 3'd4, 8'hFF);
    end else begin
      v8  = 1'b0;
      v16 = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dv[k] = sel ? done8 : done16;
    end
    if (sel) res = 32'(out8);
    else     res = 32'(out16);
    check({tag, "_done"}, 32'(dv), 32'b100);
    @(posedge clk); #1;
  endtask

  logic [31:0] r;
  logic [2:0]  dv3;

  initial begin
    reset = 1'b1; v16 = 1'b0; v8 = 1'b0; ins16 = '0; ins8 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready16", 32'(rdy16), 32'd0);
    check("rst_ready8",  32'(rdy8),  32'd0);
    check("rst_done",    32'(done16), 32'd0);
    check("rst_dout",    32'(out16), 32'd0);
    check("rst_flags",   32'(fl16),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(rdy16), 32'd1);
    @(posedge clk); #1;

    // Basic immediate add and register readback
    issue(0, 0, enc_i(OP_ADD, 3'd1, 8'h05), "add_imm", r);
    check("add_imm_dout", r, 32'h0005);
    check("add_imm_flags", 32'(fl16), fx(3'b000));
    issue(0, 0, enc_i(OP_OR, 3'd1, 8'h00), "rd_r1", r);
    check("rd_r1_dout", r, 32'h0005);

    // Subtract with borrow: 5 - 6 wraps to 0xFFFF
    issue(0, 0, enc_i(OP_SUB, 3'd1, 8'h06), "sub", r);
    check("sub_dout", r, 32'hFFFF);
    check("sub_flags", 32'(fl16), fx(3'b110));
    issue(0, 0, enc_i(OP_ADD, 3'd2, 8'h01), "r2", r);
    check("r2_dout", r, 32'h0001);

    // Register add with carry-out: 0xFFFF + 1
    issue(0, 0, enc_r(OP_ADD, 3'd1, 3'd2), "add_carry", r);
    check("add_carry_dout", r, 32'h0000);
    check("add_carry_flags", 32'(fl16), fx(3'b011));

    // nop leaves C, flags and R untouched
    issue(0, 0, enc_i(OP_ADD, 3'd1, 8'h77) | 16'h0002, "nop", r);
    check("nop_dout", r, 32'h0000);
    check("nop_flags", 32'(fl16), fx(3'b011));
    issue(0, 0, enc_i(OP_OR, 3'd1, 8'h00), "nop_rd_r1", r);
    check("nop_rd_r1_dout", r, 32'h0000);

    // rx==ry uses pre-instruction value; shifts and compares
    issue(0, 0, enc_i(OP_OR, 3'd3, 8'hA5), "r3", r);
    check("r3_dout", r, 32'h00A5);
    issue(0, 0, enc_r(OP_ADD, 3'd3, 3'd3), "self_add", r);
    check("self_add_dout", r, 32'h014A);
    issue(0, 0, enc_i(OP_SHL, 3'd3, 8'h08), "shl", r);
    check("shl_dout", r, 32'h4A00);
    check("shl_flags", 32'(fl16), fx(3'b010));
    issue(0, 0, enc_i(OP_SHR, 3'd3, 8'h13), "shr", r);
    check("shr_dout", r, 32'h0940);
    check("shr_flags", 32'(fl16), fx(3'b000));
    issue(0, 0, enc_i(OP_CMP, 3'd3, 8'h40), "cmp_gt", r);
    check("cmp_gt_dout", r, 32'h0002);
    issue(0, 0, enc_i(OP_CMP, 3'd3, 8'h02), "cmp_eq", r);
    check("cmp_eq_dout", r, 32'h0000);
    check("cmp_eq_flags", 32'(fl16), fx(3'b001));
    issue(0, 0, enc_i(OP_CMP, 3'd3, 8'h01), "cmp_lt", r);
    check("cmp_lt_dout", r, 32'h0001);
    issue(0, 0, enc_i(OP_XOR, 3'd3, 8'h03), "xor", r);
    check("xor_dout", r, 32'h0002);

    // Back-to-back with instr_valid held high, junk word while busy
    issue(0, 1, enc_i(OP_ADD, 3'd4, 8'h01), "b2b0", r);
    check("b2b0_dout", r, 32'd1);
    issue(0, 1, enc_i(OP_ADD, 3'd4, 8'h02), "b2b1", r);
    check("b2b1_dout", r, 32'd3);
    issue(0, 1, enc_i(OP_ADD, 3'd4, 8'h03), "b2b2", r);
    check("b2b2_dout", r, 32'd6);
    issue(0, 0, enc_r(OP_ADD, 3'd4, 3'd4), "b2b3", r);
    check("b2b3_dout", r, 32'd12);

    // Reset during EXEC aborts the instruction
    ins16 = enc_i(OP_ADD, 3'd5, 8'h09); v16 = 1'b1;
    @(negedge clk);
    check("rexec_ready", 32'(rdy16), 32'd1);
    @(posedge clk); #1; v16 = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("rexec_ready_in_rst", 32'(rdy16), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("rexec_no_done", 32'(done16), 32'd0);
    check("rexec_ready_after", 32'(rdy16), 32'd1);
    @(posedge clk); #1;
    issue(0, 0, enc_i(OP_OR, 3'd5, 8'h00), "rd_r5", r);
    check("rd_r5_dout", r, 32'h0000);
    issue(0, 0, enc_i(OP_OR, 3'd3, 8'h00), "rd_r3", r);
    check("rd_r3_dout", r, 32'h0000);

    // Reset overrides a simultaneous handshake
    reset = 1'b1; ins16 = enc_i(OP_ADD, 3'd6, 8'h33); v16 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; v16 = 1'b0;
    @(negedge clk);
    check("rhs_ready", 32'(rdy16), 32'd1);
    dv3[0] = done16;
    @(negedge clk); dv3[1] = done16;
    @(negedge clk); dv3[2] = done16;
    check("rhs_no_done", 32'(dv3), 32'd0);
    check("rhs_dout", 32'(out16), 32'd0);
    @(posedge clk); #1;

    // 8-bit, 4-register build
    issue(1, 0, enc_i(OP_ADD, 3'd6, 8'h2A), "w8_rx6", r);
    check("w8_rx6_dout", r, 32'h2A);
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, enc_i(OP_OR, 3'(i), 8'h00), "w8_rd", r);
      check("w8_rd_dout", r, 32'h00);
    end
    issue(1, 0, enc_i(OP_ADD, 3'd6, 8'h01), "w8_rx6_zero", r);
    check("w8_rx6_zero_dout", r, 32'h01);
    issue(1, 0, enc_i(OP_ADD, 3'd0, 8'h03), "w8_r0", r);
    check("w8_r0_dout", r, 32'h03);
    issue(1, 0, enc_i(OP_CMP, 3'd0, 8'h07), "w8_cmp", r);
    check("w8_cmp_dout", r, 32'h01);
    issue(1, 0, enc_i(OP_ADD, 3'd1, 8'hFF), "w8_ff", r);
    check("w8_ff_dout", r, 32'hFF);
    check("w8_ff_flags", 32'(fl8), fx(3'b100));
    issue(1, 0, enc_i(OP_ADD, 3'd1, 8'h02), "w8_wrap", r);
    check("w8_wrap_dout", r, 32'h01);
    check("w8_wrap_flags", 32'(fl8), fx(3'b010));
    issue(1, 0, enc_i(OP_SHL, 3'd1, 8'h0F), "w8_shl", r);
    check("w8_shl_dout", r, 32'h80);
    check("w8_shl_flags", 32'(fl8), fx(3'b100));
    issue(1, 0, enc_r(OP_ADD, 3'd0, 3'd5), "w8_ry5", r);
    check("w8_ry5_dout", r, 32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bitty_param.md
BITTY_PARAM -- requirements
Module: bitty_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values 8, 16 and 32.
REQ-002 SHALL have parameter NREGS, default 8, register-file depth; legal values 2, 4 and 8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_instr  input  16  instruction word.
REQ-006 instr_valid  input  1  d_instr is valid this cycle.
REQ-007 instr_ready  output  1  block accepts an instruction this cycle.
REQ-008 d_out  output  WIDTH  last ALU result (C register).
REQ-009 done  output  1  one-cycle pulse marking instruction retirement.
REQ-010 flags  output  3  {neg, carry, zero} from the last retired instruction.

Function
REQ-011 Instruction fields SHALL be: [15:13] rx; [12:10] ry; [12:5] imm8; [4:2] op; [1] nop; [0] imm_mode.
REQ-012 Handshake SHALL complete when instr_valid && instr_ready; the word is captured into the instruction register on that edge.
REQ-013 instr_ready SHALL equal (state == IDLE); instr_valid while busy SHALL be ignored, with no queueing.
REQ-014 FSM SHALL be IDLE -> LOAD_S -> EXEC -> WRITE -> IDLE; IDLE leaves only on handshake; other states advance unconditionally.
REQ-015 LOAD_S: S <= R[rx].
REQ-016 EXEC: C <= alu(S, operand); operand = R[ry] if imm_mode=0, else imm8 zero-extended to WIDTH.
REQ-017 WRITE: R[rx] <= C; done=1 for exactly this cycle; done is therefore high 3 cycles after the handshake edge.
REQ-018 Back-to-back: instr_ready SHALL be high in the cycle after WRITE; throughput is 1 instruction per 4 cycles.
REQ-019 op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr (logical), 7 cmp.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH.
REQ-021 Shift amount SHALL be operand[log2(WIDTH)-1:0].
REQ-022 cmp result SHALL be 0 if S==operand, 1 if S<operand (unsigned), 2 if S>operand.
REQ-023 nop=1 SHALL still traverse all states and pulse done, but C, R and flags SHALL be unchanged.
REQ-024 rx or ry >= NREGS SHALL read as 0; a write to rx >= NREGS SHALL be discarded (C is still updated).
REQ-025 When rx==ry, the operand SHALL be the pre-instruction value of R[rx].

Reset
REQ-026 While reset=1: state=IDLE, all R[i]=0, S=0, C=0, instruction register=0, flags=0, done=0.
REQ-027 instr_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-028 reset in any state SHALL abort the instruction: no write-back and no done pulse.
REQ-029 reset SHALL override a simultaneous handshake; the instruction is dropped.

Configuration
REQ-030 Macro BITTY_FLAGS_EN SHALL control flag generation.
REQ-031 With BITTY_FLAGS_EN defined, flags SHALL update in EXEC, except on nop:
- zero = (result == 0)
- neg = result[WIDTH-1]
- carry = carry-out on add, borrow on sub, last bit shifted out on shl/shr, 0 on all other ops.
REQ-032 Without BITTY_FLAGS_EN, flags SHALL be constant 3'b000 and no flag logic is synthesised.

Structure
REQ-033 Package bitty_pkg SHALL hold the op enum, FSM state enum, and instruction field position constants.
REQ-034 Sub-module bitty_alu_p SHALL be the combinational ALU, parameterised by WIDTH, outputting result and carry.
REQ-035 The register file SHALL be an array inside bitty_param with one write port and two read ports.

Verification
REQ-036 WIDTH=16: after reset, imm add rx=1 imm8=0x05 -> done 3 cycles after handshake, d_out=0x0005, R1=5.
REQ-037 R1=0xFFFF, R2=0x0001, add rx=1 ry=2 with BITTY_FLAGS_EN -> d_out=0x0000, flags=3'b011.
REQ-038 instr_valid held high continuously with 4 instructions -> handshakes 4 cycles apart and 4 done pulses, with no instruction lost or duplicated.
REQ-039 reset asserted in EXEC -> no done pulse, R[rx] unchanged at 0, instr_ready=1 in the cycle after reset deasserts.
REQ-040 NREGS=4, WIDTH=8: write rx=6 -> done pulses with d_out = result, R0..R3 unchanged; cmp R0=3 vs imm 7 -> d_out=0x01.
REQ-041 Instruction with nop=1 -> done pulse 3 cycles after handshake; d_out, all R and flags unchanged.
